// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types, widths and lane helpers for the data memory responder
package data_mem_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  function automatic logic [7:0] lane_select(input logic [DATA_W-1:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [DATA_W-1:0] sign_extend8(input logic [7:0] b);
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - store-word merge and load extraction for word and byte accesses
module mem_byte_lane
  import data_mem_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [1:0]        lane,
  input  logic [7:0]        byte_data,
  input  logic [DATA_W-1:0] word_data,
  input  logic              byte_op,
  output logic [DATA_W-1:0] store_word,
  output logic [DATA_W-1:0] load_value
);

  // A byte store rewrites one lane of the existing word; little-endian, lane 0 is bits [7:0].
  always_comb begin
    store_word = word_data;
    if (byte_op) begin
      store_word = old_word;
      store_word[{lane, 3'b000} +: 8] = byte_data;
    end
  end

  assign load_value = byte_op ? sign_extend8(lane_select(old_word, lane)) : old_word;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - handshaked data memory with programmable wait states and byte access
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              byteOperations,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] read_data,
  output logic              resp_error
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t state, state_next;
  logic [3:0]        wait_cnt;
  logic              rd_q, wr_q, byte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [15:0]       word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              accept, do_access, access_err;
  logic [DATA_W-1:0] old_word, store_word, load_value;

  assign word_idx  = addr_q[ADDR_W-1:2];
  assign mem_idx   = word_idx[IDX_W-1:0];
  assign old_word  = mem[mem_idx];

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP);
  assign accept     = (state == IDLE) && req_valid;
  assign do_access  = (state == BUSY) && (wait_cnt == 4'd0);

  // rd_q == wr_q covers both "load and store" and "neither".
  assign access_err = (rd_q == wr_q)
                    || (!byte_q && (addr_q[1:0] != 2'b00))
                    || ({1'b0, word_idx} >= 17'(DEPTH_WORDS));

  mem_byte_lane u_lane (
    .old_word   (old_word),
    .lane       (addr_q[1:0]),
    .byte_data  (wdata_q[7:0]),
    .word_data  (wdata_q),
    .byte_op    (byte_q),
    .store_word (store_word),
    .load_value (load_value)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = BUSY;
      BUSY:    if (wait_cnt == 4'd0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      read_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        rd_q     <= memRead;
        wr_q     <= memWrite;
        byte_q   <= byteOperations;
        addr_q   <= address;
        wdata_q  <= write_data;
        wait_cnt <= 4'(WAIT_STATES);
      end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (do_access) begin
        read_data  <= (access_err || wr_q) ? '0 : load_value;
        resp_error <= access_err;
      end
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (!reset && do_access && wr_q && !access_err) begin
      mem[mem_idx] <= store_word;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at 2 and 0 wait states
module tb_data_mem_responder;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        bop;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } req_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          acc;
  } sb_t;

  logic        clock = 1'b0;
  logic        reset [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        memRead [2];
  logic        memWrite [2];
  logic        byteOperations [2];
  logic [17:0] address [2];
  logic [31:0] write_data [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] read_data [2];
  logic        resp_error [2];

  req_t        pend [$];
  sb_t         sb [$];
  logic [31:0] ref_mem [int];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clock = ~clock;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut_ws2 (
    .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .memRead(memRead[0]), .memWrite(memWrite[0]), .byteOperations(byteOperations[0]),
    .address(address[0]), .write_data(write_data[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .read_data(read_data[0]), .resp_error(resp_error[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_ws0 (
    .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .memRead(memRead[1]), .memWrite(memWrite[1]), .byteOperations(byteOperations[1]),
    .address(address[1]), .write_data(write_data[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .read_data(read_data[1]), .resp_error(resp_error[1])
  );

  function automatic int ws_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: computes the response and updates the bench copy of memory.
  task automatic add(input int u, input logic rd, input logic wr, input logic bop,
                     input logic [17:0] a, input logic [31:0] wd);
    req_t        r;
    int          idx;
    int          key;
    int          sh;
    logic [31:0] word;
    logic [7:0]  b;
    idx = int'(a[17:2]);
    key = u * 65536 + idx;
    sh  = 8 * int'(a[1:0]);
    r.rd = rd; r.wr = wr; r.bop = bop; r.addr = a; r.wdata = wd;
    r.exp_data = 32'h0;
    r.exp_err  = (rd && wr) || (!rd && !wr) || (!bop && a[1:0] != 2'b00) || (idx >= 1024);
    if (!r.exp_err) begin
      word = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
      if (wr) begin
        if (bop) word = (word & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
        else     word = wd;
        ref_mem[key] = word;
      end else if (bop) begin
        b = 8'(word >> sh);
        r.exp_data = {{24{b[7]}}, b};
      end else begin
        r.exp_data = word;
      end
    end
    pend.push_back(r);
  endtask

  task automatic drive(input int u, input req_t r);
    memRead[u]        = r.rd;
    memWrite[u]       = r.wr;
    byteOperations[u] = r.bop;
    address[u]        = r.addr;
    write_data[u]     = r.wdata;
  endtask

  // Issues every queued request as fast as the DUT accepts them, checking data, latency and spacing.
  task automatic run_stream(input int u);
    int   n;
    int   k;
    int   got;
    int   cyc;
    int   last_resp;
    logic was_ready;
    req_t cur;
    sb_t  e;
    n = pend.size(); k = 0; got = 0; cyc = 0; last_resp = -1;
    while (got < n && cyc < 300) begin
      if (k < n && !req_valid[u]) begin
        cur = pend[k];
        drive(u, cur);
        req_valid[u] = 1'b1;
      end
      was_ready = req_ready[u];
      @(posedge clock); #1;
      cyc++;
      if (was_ready && req_valid[u]) begin
        sb.push_back('{cur.exp_data, cur.exp_err, cyc});
        k++;
        req_valid[u] = 1'b0;
      end
      if (resp_valid[u]) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("u%0d_data", u), read_data[u], e.d);
          check($sformatf("u%0d_err", u), 32'(resp_error[u]), 32'(e.e));
          check($sformatf("u%0d_latency", u), 32'(cyc - e.acc), 32'(ws_of(u) + 1));
          if (last_resp >= 0)
            check($sformatf("u%0d_interval", u), 32'(cyc - last_resp), 32'(ws_of(u) + 3));
        end
        last_resp = cyc;
        got++;
      end
    end
    if (got < n) check("stream_timeout", 32'(got), 32'(n));
    req_valid[u] = 1'b0;
    pend.delete();
    sb.delete();
  endtask

  initial begin
    req_t r;
    int   t;
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; req_valid[u] = 1'b0; memRead[u] = 1'b0; memWrite[u] = 1'b0;
      byteOperations[u] = 1'b0; address[u] = '0; write_data[u] = '0; resp_ready[u] = 1'b1;
    end
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready_ws2", 32'(req_ready[0]), 32'd0);
    check("rst_ready_ws0", 32'(req_ready[1]), 32'd0);
    reset[0] = 1'b0; reset[1] = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check("post_rst_resp_valid", 32'(resp_valid[u]), 32'd0);
      check("post_rst_read_data", read_data[u], 32'd0);
      check("post_rst_resp_error", 32'(resp_error[u]), 32'd0);
      check("post_rst_req_ready", 32'(req_ready[u]), 32'd1);
    end

    // Word and byte accesses, two wait states.
    add(0, 1'b0, 1'b1, 1'b0, 18'h00010, 32'hDEADBEEF);
    add(0, 1'b1, 1'b0, 1'b0, 18'h00010, 32'h0);
    add(0, 1'b0, 1'b1, 1'b1, 18'h00013, 32'h000000A5);
    add(0, 1'b1, 1'b0, 1'b1, 18'h00013, 32'h0);
    add(0, 1'b1, 1'b0, 1'b0, 18'h00010, 32'h0);
    add(0, 1'b1, 1'b0, 1'b1, 18'h00011, 32'h0);
    add(0, 1'b0, 1'b1, 1'b1, 18'h00010, 32'h1234567F);
    add(0, 1'b1, 1'b0, 1'b1, 18'h00010, 32'h0);
    add(0, 1'b1, 1'b0, 1'b0, 18'h00010, 32'h0);
    run_stream(0);

    // Backpressure on a load response, with a competing request that must be ignored.
    add(0, 1'b1, 1'b0, 1'b0, 18'h00010, 32'h0);
    r = pend.pop_front();
    resp_ready[0] = 1'b0;
    drive(0, r);
    req_valid[0] = 1'b1;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    t = 0;
    while (!resp_valid[0] && t < 20) begin @(posedge clock); #1; t++; end
    check("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
    check("bp_data", read_data[0], r.exp_data);
    memRead[0] = 1'b0; memWrite[0] = 1'b1; byteOperations[0] = 1'b0;
    address[0] = 18'h00010; write_data[0] = 32'hFFFFFFFF; req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("bp_hold_valid", 32'(resp_valid[0]), 32'd1);
      check("bp_hold_data", read_data[0], r.exp_data);
      check("bp_hold_ready", 32'(req_ready[0]), 32'd0);
    end
    resp_ready[0] = 1'b1;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    check("bp_release", 32'(resp_valid[0]), 32'd0);

    // Error cases, followed by proof that memory was untouched.
    add(0, 1'b1, 1'b0, 1'b0, 18'h00011, 32'h0);
    add(0, 1'b1, 1'b1, 1'b0, 18'h00010, 32'h11111111);
    add(0, 1'b1, 1'b0, 1'b0, 18'h3FFFC, 32'h0);
    add(0, 1'b0, 1'b0, 1'b0, 18'h00010, 32'h22222222);
    add(0, 1'b0, 1'b1, 1'b0, 18'h00012, 32'h33333333);
    add(0, 1'b0, 1'b1, 1'b1, 18'h01000, 32'h44444444);
    add(0, 1'b1, 1'b0, 1'b0, 18'h00010, 32'h0);
    add(0, 1'b0, 1'b1, 1'b0, 18'h00020, 32'h0BADF00D);
    run_stream(0);

    // Reset while BUSY aborts a store.
    memRead[0] = 1'b0; memWrite[0] = 1'b1; byteOperations[0] = 1'b0;
    address[0] = 18'h00020; write_data[0] = 32'h12345678; req_valid[0] = 1'b1;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    reset[0] = 1'b1;
    @(posedge clock); #1;
    reset[0] = 1'b0;
    #1;
    check("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("abort_req_ready", 32'(req_ready[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("abort_no_resp", 32'(resp_valid[0]), 32'd0);
    end
    add(0, 1'b1, 1'b0, 1'b0, 18'h00020, 32'h0);
    run_stream(0);

    // Reset while RESP drops the response.
    add(0, 1'b1, 1'b0, 1'b0, 18'h00020, 32'h0);
    r = pend.pop_front();
    resp_ready[0] = 1'b0;
    drive(0, r);
    req_valid[0] = 1'b1;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    t = 0;
    while (!resp_valid[0] && t < 20) begin @(posedge clock); #1; t++; end
    check("drop_resp_seen", 32'(resp_valid[0]), 32'd1);
    reset[0] = 1'b1;
    @(posedge clock); #1;
    reset[0] = 1'b0;
    resp_ready[0] = 1'b1;
    #1;
    check("drop_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("drop_read_data", read_data[0], 32'd0);

    // Zero wait states: back-to-back stores then loads.
    add(1, 1'b0, 1'b1, 1'b0, 18'h00000, 32'h01020304);
    add(1, 1'b0, 1'b1, 1'b0, 18'h00004, 32'hCAFEF00D);
    add(1, 1'b0, 1'b1, 1'b0, 18'h00008, 32'h80FF7F00);
    add(1, 1'b0, 1'b1, 1'b1, 18'h00009, 32'hFFFFFF55);
    run_stream(1);
    add(1, 1'b1, 1'b0, 1'b0, 18'h00000, 32'h0);
    add(1, 1'b1, 1'b0, 1'b0, 18'h00004, 32'h0);
    add(1, 1'b1, 1'b0, 1'b0, 18'h00008, 32'h0);
    add(1, 1'b1, 1'b0, 1'b1, 18'h0000B, 32'h0);
    add(1, 1'b1, 1'b0, 1'b1, 18'h00009, 32'h0);
    add(1, 1'b1, 1'b0, 1'b0, 18'h00006, 32'h0);
    run_stream(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
